// File: rtl/gpio_in_sampler.sv
// gpio_in_sampler: synchronizes the asynchronous GPIO byte bus and strobe,
// captures one byte per strobe rising edge into a FIFO and emits single-cycle
// ready-gated beats, with busy back-pressure, overflow and byte-count status.
module gpio_in_sampler #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [7:0]                         in_GPIO,
    input  logic                               in_GPIO_strobe,
    input  logic                               conf_sys_ctrl_reg_RESET,
    input  logic                               i_out_ready,
    output logic [7:0]                         in_GPIO_sampled,
    output logic                               in_GPIO_valid_sampled,
    output logic                               gpio_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic                               gpio_overflow,
    output logic [15:0]                        gpio_byte_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH+1);
    localparam int unsigned ARM_W = $clog2(SYNC_STAGES+2);
    localparam logic [ARM_W-1:0] ARM_DONE  = ARM_W'(SYNC_STAGES+1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_BUSY  = LVL_W'(FIFO_DEPTH-2);

    logic [SYNC_STAGES-1:0] strobe_sync;
    logic [7:0]             data_sync [SYNC_STAGES];
    logic                   strobe_d;
    logic                   soft_q;
    logic [ARM_W-1:0]       arm_cnt;

    logic [7:0]             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;

    logic                   armed;
    logic                   edge_det;
    logic                   soft_edge;
    logic                   push_req;
    logic                   fifo_full;
    logic                   pop;
    logic                   push;
    logic                   drop;
    logic [LVL_W-1:0]       level_next;

    // Synchronizer chains for strobe and data, equal depth so the byte aligns with its strobe
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            strobe_sync <= '0;
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                data_sync[i] <= '0;
            end
        end else begin
            strobe_sync  <= {strobe_sync[SYNC_STAGES-2:0], in_GPIO_strobe};
            data_sync[0] <= in_GPIO;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                data_sync[i] <= data_sync[i-1];
            end
        end
    end

    // Edge-detect copies, soft-reset edge copy and post-reset arming counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            strobe_d <= 1'b0;
            soft_q   <= 1'b0;
            arm_cnt  <= '0;
        end else begin
            strobe_d <= strobe_sync[SYNC_STAGES-1];
            soft_q   <= conf_sys_ctrl_reg_RESET;
            if (arm_cnt != ARM_DONE) begin
                arm_cnt <= arm_cnt + 1'b1;
            end
        end
    end

    // Push/pop decisions; pop uses the occupancy before this edge's push
    always_comb begin
        armed      = (arm_cnt == ARM_DONE);
        edge_det   = strobe_sync[SYNC_STAGES-1] & ~strobe_d;
        soft_edge  = conf_sys_ctrl_reg_RESET & ~soft_q;
        push_req   = armed & edge_det;
        fifo_full  = (fifo_level == LVL_FULL);
        pop        = i_out_ready & (fifo_level != '0);
        push       = push_req & (~fifo_full | pop);
        drop       = push_req & fifo_full & ~pop;
        level_next = fifo_level + {{(LVL_W-1){1'b0}}, push} - {{(LVL_W-1){1'b0}}, pop};
    end

    // FIFO storage, output beat register and status flags; soft reset flushes and clears status
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr                <= '0;
            rd_ptr                <= '0;
            fifo_level            <= '0;
            in_GPIO_sampled       <= '0;
            in_GPIO_valid_sampled <= 1'b0;
            gpio_busy             <= 1'b0;
            gpio_overflow         <= 1'b0;
            gpio_byte_count       <= '0;
        end else if (soft_edge) begin
            wr_ptr                <= '0;
            rd_ptr                <= '0;
            fifo_level            <= '0;
            in_GPIO_valid_sampled <= 1'b0;
            gpio_busy             <= 1'b0;
            gpio_overflow         <= 1'b0;
            gpio_byte_count       <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= data_sync[SYNC_STAGES-1];
                wr_ptr      <= wr_ptr + 1'b1;
                if (gpio_byte_count != '1) begin
                    gpio_byte_count <= gpio_byte_count + 16'd1;
                end
            end
            if (pop) begin
                in_GPIO_sampled <= mem[rd_ptr];
                rd_ptr          <= rd_ptr + 1'b1;
            end
            if (drop) begin
                gpio_overflow <= 1'b1;
            end
            in_GPIO_valid_sampled <= pop;
            fifo_level            <= level_next;
            gpio_busy             <= (level_next >= LVL_BUSY);
        end
    end

endmodule

// File: tb/tb_gpio_in_sampler.sv
// tb_gpio_in_sampler: table-driven single-byte vectors plus hand-written
// multi-cycle sequences; output beats are checked against a scoreboard queue.
module tb_gpio_in_sampler;

    localparam int unsigned DEPTH = 8;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [7:0]  in_GPIO;
    logic        in_GPIO_strobe;
    logic        conf_sys_ctrl_reg_RESET;
    logic        i_out_ready;
    logic [7:0]  in_GPIO_sampled;
    logic        in_GPIO_valid_sampled;
    logic        gpio_busy;
    logic [3:0]  fifo_level;
    logic        gpio_overflow;
    logic [15:0] gpio_byte_count;

    int checks   = 0;
    int failures = 0;
    int beats    = 0;
    logic [7:0] exp_q [$];

    gpio_in_sampler #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .i_clk                   (i_clk),
        .i_rst                   (i_rst),
        .in_GPIO                 (in_GPIO),
        .in_GPIO_strobe          (in_GPIO_strobe),
        .conf_sys_ctrl_reg_RESET (conf_sys_ctrl_reg_RESET),
        .i_out_ready             (i_out_ready),
        .in_GPIO_sampled         (in_GPIO_sampled),
        .in_GPIO_valid_sampled   (in_GPIO_valid_sampled),
        .gpio_busy               (gpio_busy),
        .fifo_level              (fifo_level),
        .gpio_overflow           (gpio_overflow),
        .gpio_byte_count         (gpio_byte_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] exp_count;
        int          exp_latency;
    } vec_t;

    vec_t vecs [4];

    // Scoreboard: every valid beat must match the oldest expected byte
    always @(negedge i_clk) begin
        if (!i_rst && in_GPIO_valid_sampled) begin
            beats++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat actual=%02h required=no_beat", in_GPIO_sampled);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (in_GPIO_sampled !== e) begin
                    failures++;
                    $display("FAIL beat_data actual=%02h required=%02h", in_GPIO_sampled, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One strobe: data set a clock early, strobe high 4 clocks, low 4 clocks
    task automatic send_byte(input logic [7:0] d, input bit expect_out);
        @(negedge i_clk);
        in_GPIO = d;
        @(negedge i_clk);
        in_GPIO_strobe = 1'b1;
        if (expect_out) exp_q.push_back(d);
        repeat (4) @(negedge i_clk);
        in_GPIO_strobe = 1'b0;
        repeat (4) @(negedge i_clk);
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 60; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge i_clk);
        end
        @(negedge i_clk);
        chk(name, exp_q.size(), 0);
    endtask

    task automatic soft_reset_pulse();
        @(negedge i_clk);
        conf_sys_ctrl_reg_RESET = 1'b1;
        @(negedge i_clk);
        conf_sys_ctrl_reg_RESET = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int b0;

        vecs[0] = '{data: 8'hA5, exp_count: 16'd1, exp_latency: 4};
        vecs[1] = '{data: 8'h00, exp_count: 16'd2, exp_latency: 4};
        vecs[2] = '{data: 8'hFF, exp_count: 16'd3, exp_latency: 4};
        vecs[3] = '{data: 8'h5A, exp_count: 16'd4, exp_latency: 4};

        i_rst = 1'b1;
        in_GPIO = 8'h00;
        in_GPIO_strobe = 1'b0;
        conf_sys_ctrl_reg_RESET = 1'b0;
        i_out_ready = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("rst_valid", in_GPIO_valid_sampled, 0);
        chk("rst_data", in_GPIO_sampled, 0);
        chk("rst_busy", gpio_busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_overflow", gpio_overflow, 0);
        chk("rst_count", gpio_byte_count, 0);
        i_rst = 1'b0;
        repeat (4) @(negedge i_clk);

        // Table-driven single bytes with latency measurement
        i_out_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            in_GPIO = vecs[v].data;
            @(negedge i_clk);
            in_GPIO_strobe = 1'b1;
            exp_q.push_back(vecs[v].data);
            lat = 0;
            for (int k = 1; k <= 10; k++) begin
                @(negedge i_clk);
                if (in_GPIO_valid_sampled && lat == 0) lat = k;
                if (k == 4) in_GPIO_strobe = 1'b0;
            end
            chk($sformatf("latency_%0d", v), lat, vecs[v].exp_latency);
            chk($sformatf("count_%0d", v), gpio_byte_count, vecs[v].exp_count);
            chk($sformatf("level_%0d", v), fifo_level, 0);
        end
        chk("single_drain", exp_q.size(), 0);

        // Back-pressure: 6 queued bytes, busy threshold at DEPTH-2
        i_out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            send_byte(8'(i), 1'b1);
            if (i == 5) chk("busy_below_thresh", gpio_busy, 0);
        end
        chk("bp_level", fifo_level, 6);
        chk("bp_busy", gpio_busy, 1);
        b0 = beats;
        i_out_ready = 1'b1;
        @(negedge i_clk);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("bp_consec_%0d", i), in_GPIO_valid_sampled, 1);
            @(negedge i_clk);
        end
        chk("bp_beats", beats - b0, 6);
        chk("bp_busy_clear", gpio_busy, 0);
        wait_drain("bp_drain");

        // Overflow: 10 bytes into an 8-deep FIFO with no pops
        soft_reset_pulse();
        i_out_ready = 1'b0;
        for (int i = 0; i < 10; i++) send_byte(8'h10 + 8'(i), i < 8);
        chk("ovf_level", fifo_level, 8);
        chk("ovf_flag", gpio_overflow, 1);
        chk("ovf_count", gpio_byte_count, 8);
        i_out_ready = 1'b1;
        wait_drain("ovf_drain");
        chk("ovf_sticky", gpio_overflow, 1);

        // Push landing on a pop edge while full
        soft_reset_pulse();
        chk("sr_clears_ovf", gpio_overflow, 0);
        i_out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_byte(8'h20 + 8'(i), 1'b1);
        chk("full_level", fifo_level, 8);
        @(negedge i_clk);
        in_GPIO = 8'h99;
        @(negedge i_clk);
        in_GPIO_strobe = 1'b1;
        exp_q.push_back(8'h99);
        @(negedge i_clk);
        @(negedge i_clk);
        i_out_ready = 1'b1;
        @(negedge i_clk);
        chk("pp_level", fifo_level, 8);
        chk("pp_overflow", gpio_overflow, 0);
        chk("pp_valid", in_GPIO_valid_sampled, 1);
        repeat (2) @(negedge i_clk);
        in_GPIO_strobe = 1'b0;
        wait_drain("pp_drain");
        chk("pp_count", gpio_byte_count, 9);
        chk("pp_overflow_end", gpio_overflow, 0);

        // Soft reset flushes queued bytes
        i_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(8'h40 + 8'(i), 1'b0);
        chk("sr_pre_level", fifo_level, 4);
        @(negedge i_clk);
        conf_sys_ctrl_reg_RESET = 1'b1;
        @(negedge i_clk);
        chk("sr_level", fifo_level, 0);
        chk("sr_count", gpio_byte_count, 0);
        chk("sr_overflow", gpio_overflow, 0);
        conf_sys_ctrl_reg_RESET = 1'b0;
        i_out_ready = 1'b1;
        b0 = beats;
        repeat (6) @(negedge i_clk);
        chk("sr_no_beats", beats - b0, 0);
        send_byte(8'h3C, 1'b1);
        wait_drain("sr_drain");
        chk("sr_post_count", gpio_byte_count, 1);

        // Strobe held high through reset must not push
        @(negedge i_clk);
        in_GPIO = 8'h66;
        in_GPIO_strobe = 1'b1;
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        b0 = beats;
        repeat (10) @(negedge i_clk);
        chk("hold_count", gpio_byte_count, 0);
        chk("hold_level", fifo_level, 0);
        chk("hold_beats", beats - b0, 0);
        in_GPIO = 8'h77;
        in_GPIO_strobe = 1'b0;
        repeat (4) @(negedge i_clk);
        in_GPIO_strobe = 1'b1;
        exp_q.push_back(8'h77);
        repeat (4) @(negedge i_clk);
        in_GPIO_strobe = 1'b0;
        wait_drain("hold_drain");
        chk("hold_post_count", gpio_byte_count, 1);
        chk("hold_post_beats", beats - b0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpio_in_sampler.md
Name: gpio_in_sampler

Overview:
- Front-end stage directly upstream of the initial-spin and coefficient RF write controllers.
- Synchronizes the asynchronous off-chip 8-bit GPIO bus and its strobe into i_clk, and captures one byte per strobe rising edge into a small FIFO.
- Emits bytes as single-cycle in_GPIO_sampled / in_GPIO_valid_sampled beats, gated by a downstream ready.
- Provides pad-side busy back-pressure plus overflow and byte-count status.

Parameters:
- FIFO_DEPTH, 8: byte FIFO entries; power of 2, at least 4.
- SYNC_STAGES, 2: synchronizer flops on both the strobe and data paths; at least 2.

Ports:
- i_clk  input  1  single system clock.
- i_rst  input  1  reset, synchronous, active-high.
- in_GPIO  input  8  asynchronous pad data.
- in_GPIO_strobe  input  1  asynchronous pad strobe; a rising edge marks one byte.
- conf_sys_ctrl_reg_RESET  input  1  soft-reset level; its rising edge flushes the block.
- i_out_ready  input  1  downstream can accept a byte next cycle.
- in_GPIO_sampled  output  8  byte presented downstream.
- in_GPIO_valid_sampled  output  1  one-cycle beat qualifying in_GPIO_sampled.
- gpio_busy  output  1  pad-side back-pressure; the host must pause strobing.
- fifo_level  output  $clog2(FIFO_DEPTH+1)  current occupancy.
- gpio_overflow  output  1  sticky flag: a byte was dropped.
- gpio_byte_count  output  16  bytes accepted into the FIFO, saturating.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values (i_rst high at a clock edge): every flop is 0, including both sync chains and the edge flop. All outputs read 0. The arm counter is cleared.
- Arming after reset: edge detection is suppressed until SYNC_STAGES+1 clocks after i_rst deasserts. A strobe held high through reset therefore never produces a push.
- Synchronizer: strobe and data each pass through SYNC_STAGES flops. The data chain has the same depth so the captured byte aligns with the strobe.
- Edge detection: edge = strobe_sync & ~strobe_d, where strobe_d registers strobe_sync.
- Pad hold contract: the host holds in_GPIO stable from 1 clock before the strobe rises until SYNC_STAGES+2 clocks after.
- Push: an armed edge writes the last data-chain stage into the FIFO at the next clock edge.
  - If the FIFO is full and no pop occurs that cycle, the byte is dropped, gpio_overflow sets, and the count does not increment.
  - Otherwise gpio_byte_count increments, saturating at 0xFFFF.
- Pop / output stage:
  - At each clock edge, if i_out_ready is 1 and the FIFO is non-empty (occupancy before this edge's push), pop the head into in_GPIO_sampled and set in_GPIO_valid_sampled to 1.
  - Otherwise set valid to 0 and hold in_GPIO_sampled.
  - Each byte is therefore valid for exactly one cycle. Back-to-back beats occur while ready stays high and the FIFO is non-empty.
  - The consumer must accept every valid beat.
- Push and pop together:
  - Non-empty FIFO: both occur and the level is unchanged.
  - Full FIFO: both occur with no overflow.
  - Empty FIFO: only the push occurs; the byte pops on a later edge.
- Latency: with the FIFO empty and ready high, valid asserts SYNC_STAGES+1 clock edges after the first edge that samples the strobe high (3 edges with defaults).
- Order: FIFO order is strictly preserved. Read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- gpio_busy: registered; 1 when the next-state level is at least FIFO_DEPTH-2.
- Soft reset:
  - Rising edge of conf_sys_ctrl_reg_RESET is detected with one registered copy (reset value 0).
  - On that edge: flush the FIFO (pointers and level to 0), clear valid, busy, overflow and byte count.
  - Sync chains, strobe_d and the arm counter are unaffected.
  - An edge detected in the same cycle as the soft reset is discarded.
- Mid-operation i_rst: all state drops immediately; in-flight bytes are lost and the arming period restarts.

Test Plan:
- Single byte: reset, wait 4 clocks, set in_GPIO=0xA5 and raise strobe with ready=1 -> valid is a one-cycle pulse 3 edges later with in_GPIO_sampled=0xA5; count=1, level back to 0.
- Back-pressure: ready=0, strobe 6 bytes 0x01..0x06 -> level=6 and gpio_busy=1; raise ready -> six consecutive valid beats 0x01..0x06 in order, then busy=0.
- Overflow: ready=0, strobe 10 bytes -> level=8, gpio_overflow=1, count=8; ready=1 -> first 8 bytes emerge and overflow stays 1.
- Simultaneous push/pop at full: fill to 8, raise ready, strobe one more byte so its push lands on a pop edge -> no overflow, level stays 8 for that cycle, all 9 bytes emerge in order.
- Soft reset: 4 bytes queued, pulse conf_sys_ctrl_reg_RESET -> next cycle level=0, count=0, overflow=0, no valid beats; a following strobe byte 0x3C emerges normally.
- Reset with strobe held high: hold strobe=1 through i_rst and after it -> no push, count=0; drop then raise strobe -> exactly one byte is captured.
